// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM constants and fade envelope state encoding
//
// PWM_W        : duty / period counter width
// PWM_PERIOD   : clocks per PWM period
// fade_state_t : envelope FSM state, encoding visible on pwm_fade.phase
package pwm_pkg;

    localparam int PWM_W      = 8;
    localparam int PWM_PERIOD = 256;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_HOLD_HI = 3'd2,
        S_DOWN    = 3'd3,
        S_HOLD_LO = 3'd4
    } fade_state_t;

endpackage

// File: rtl/pwm_period_tick.sv
// rtl/pwm_period_tick.sv - free-running PWM period counter with period-end pulse
//
// Ports:
//   clk        in  system clock, shared with the PWM stage
//   rst_n      in  asynchronous active-low reset
//   period_end out registered pulse, high for the one cycle the counter reads its
//                  last value (PWM_PERIOD-1); the following edge is the wrap edge
module pwm_period_tick
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic period_end
);

    logic [PWM_W-1:0] pcnt;

    // period_end is registered, so it is raised one count early to line up
    // with the cycle in which pcnt holds the last value of the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            period_end <= 1'b0;
        end else begin
            pcnt       <= pcnt + PWM_W'(1);
            period_end <= (pcnt == PWM_W'(PWM_PERIOD - 2));
        end
    end

endmodule

// File: rtl/pwm_fade.sv
// rtl/pwm_fade.sv - breathing envelope generator feeding a PWM duty input
//
// Ramps duty_cycle from min_duty up to max_duty, dwells, ramps back down,
// dwells, and repeats while en is high. Every state / duty change lands on
// the PWM period wrap edge so the PWM stage never sees a mid-period change.
//
// Ports:
//   clk, rst_n  in  clock, asynchronous active-low reset
//   en          in  envelope enable
//   step        in  duty change per ramp step (0 behaves as 1)
//   min_duty    in  low clamp and ramp start value
//   max_duty    in  high clamp
//   div         in  extra PWM periods between ramp steps
//   hold        in  extra PWM periods spent in each hold state
//   duty_cycle  out registered duty for the PWM stage
//   phase       out current envelope state encoding
//   period_end  out pulse in the last cycle of every PWM period
//   cycle_done  out pulse in the first cycle after HOLD_LO hands back to UP
module pwm_fade
    import pwm_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       step,
    input  logic [7:0]       min_duty,
    input  logic [7:0]       max_duty,
    input  logic [DIV_W-1:0] div,
    input  logic [7:0]       hold,
    output logic [7:0]       duty_cycle,
    output logic [2:0]       phase,
    output logic             period_end,
    output logic             cycle_done
);

    fade_state_t      state_q, state_d;
    logic [PWM_W-1:0] duty_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic [7:0]       hcnt_q, hcnt_d;
    logic             done_d;

    logic [PWM_W-1:0] step_eff;
    logic [PWM_W:0]   up_sum;
    logic [PWM_W:0]   dn_diff;
    logic             step_evt;
    logic             up_clamp;
    logic             dn_clamp;

    pwm_period_tick u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .period_end (period_end)
    );

    // Ninth bit catches overflow on the way up and borrow on the way down,
    // so neither direction can wrap to the far end of the 8-bit range.
    assign step_eff = (step == '0) ? PWM_W'(1) : step;
    assign up_sum   = {1'b0, duty_cycle} + {1'b0, step_eff};
    assign dn_diff  = {1'b0, duty_cycle} - {1'b0, step_eff};
    assign step_evt = (pre_q == div);
    assign up_clamp = (up_sum >= {1'b0, max_duty});
    assign dn_clamp = dn_diff[PWM_W] || (dn_diff[PWM_W-1:0] <= min_duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            duty_cycle <= '0;
            pre_q      <= '0;
            hcnt_q     <= '0;
            cycle_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_cycle <= duty_d;
            pre_q      <= pre_d;
            hcnt_q     <= hcnt_d;
            cycle_done <= done_d;
        end
    end

    // Config inputs are only looked at while period_end is high, which is
    // what makes mid-period config writes harmless.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_cycle;
        pre_d   = pre_q;
        hcnt_d  = hcnt_q;
        done_d  = 1'b0;
        if (period_end) begin
            if (!en) begin
                state_d = S_IDLE;
                duty_d  = '0;
                pre_d   = '0;
                hcnt_d  = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_d = S_UP;
                        duty_d  = min_duty;
                        pre_d   = '0;
                        hcnt_d  = '0;
                    end
                    S_UP: begin
                        if (step_evt) begin
                            pre_d = '0;
                            if (up_clamp) begin
                                state_d = S_HOLD_HI;
                                duty_d  = max_duty;
                                hcnt_d  = '0;
                            end else begin
                                duty_d = up_sum[PWM_W-1:0];
                            end
                        end else begin
                            pre_d = pre_q + DIV_W'(1);
                        end
                    end
                    S_HOLD_HI: begin
                        if (hcnt_q == hold) begin
                            state_d = S_DOWN;
                            pre_d   = '0;
                            hcnt_d  = '0;
                        end else begin
                            hcnt_d = hcnt_q + 8'd1;
                        end
                    end
                    S_DOWN: begin
                        if (step_evt) begin
                            pre_d = '0;
                            if (dn_clamp) begin
                                state_d = S_HOLD_LO;
                                duty_d  = min_duty;
                                hcnt_d  = '0;
                            end else begin
                                duty_d = dn_diff[PWM_W-1:0];
                            end
                        end else begin
                            pre_d = pre_q + DIV_W'(1);
                        end
                    end
                    S_HOLD_LO: begin
                        if (hcnt_q == hold) begin
                            state_d = S_UP;
                            pre_d   = '0;
                            hcnt_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            hcnt_d = hcnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        duty_d  = '0;
                        pre_d   = '0;
                        hcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        phase = state_q;
    end

endmodule

// File: tb/tb_pwm_fade.sv
// tb/tb_pwm_fade.sv - self-checking bench for pwm_fade with a per-period reference model
module tb_pwm_fade;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] step, min_duty, max_duty, div, hold;
    logic [7:0] duty_cycle;
    logic [2:0] phase;
    logic       period_end, cycle_done;

    always #5 clk = ~clk;

    pwm_fade #(.DIV_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .step       (step),
        .min_duty   (min_duty),
        .max_duty   (max_duty),
        .div        (div),
        .hold       (hold),
        .duty_cycle (duty_cycle),
        .phase      (phase),
        .period_end (period_end),
        .cycle_done (cycle_done)
    );

    typedef struct {
        int st;
        int duty;
        int pre;
        int hcnt;
        bit done;
    } mstate_t;

    mstate_t    m;
    int         m_cnt;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;
    logic [7:0] seq[$];
    logic [7:0] exp_q[$];
    int         done_idx;

    // One whole PWM period of envelope behaviour, decided with plain integers.
    function automatic mstate_t period_step(mstate_t c);
        mstate_t n = c;
        int inc = (step == 8'd0) ? 1 : int'(step);
        int lo = int'(min_duty);
        int hi = int'(max_duty);
        int target;
        n.done = 1'b0;
        if (!en) begin
            if (c.st != 0) n = '{0, 0, 0, 0, 1'b0};
            return n;
        end
        case (c.st)
            0: begin
                n.st = 1; n.duty = lo; n.pre = 0; n.hcnt = 0;
            end
            1, 3: begin
                if (c.pre != int'(div)) begin
                    n.pre = c.pre + 1;
                end else begin
                    n.pre = 0;
                    if (c.st == 1) begin
                        target = c.duty + inc;
                        if (target >= hi) begin n.duty = hi; n.st = 2; n.hcnt = 0; end
                        else n.duty = target;
                    end else begin
                        target = c.duty - inc;
                        if (target <= lo) begin n.duty = lo; n.st = 4; n.hcnt = 0; end
                        else n.duty = target;
                    end
                end
            end
            default: begin
                if (c.hcnt != int'(hold)) begin
                    n.hcnt = c.hcnt + 1;
                end else begin
                    n.hcnt = 0;
                    n.pre  = 0;
                    n.st   = (c.st == 2) ? 3 : 1;
                    n.done = (c.st == 4);
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= '{0, 0, 0, 0, 1'b0};
            m_cnt <= 0;
        end else begin
            if (m_cnt == 255) m <= period_step(m);
            else m.done <= 1'b0;
            m_cnt <= (m_cnt == 255) ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (duty_cycle !== 8'(m.duty) || phase !== 3'(m.st) ||
                period_end !== (m_cnt == 255) || cycle_done !== m.done) begin
                failures++;
                $display("FAIL model_track t=%0t got duty=%h phase=%0d pe=%b cd=%b required duty=%h phase=%0d pe=%b cd=%b",
                         $time, duty_cycle, phase, period_end, cycle_done,
                         8'(m.duty), m.st, (m_cnt == 255), m.done);
            end
        end
    end

    // Collects duty_cycle in the first cycle of each of the next n periods.
    task automatic run_periods(input int n);
        seq.delete();
        done_idx = -1;
        while (seq.size() < n) begin
            @(negedge clk);
            if (m_cnt == 0) seq.push_back(duty_cycle);
            if (cycle_done) done_idx = seq.size() - 1;
        end
    endtask

    task automatic set_cfg(input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] st,
                           input logic [7:0] dv, input logic [7:0] hd);
        min_duty = mn; max_duty = mx; step = st; div = dv; hold = hd;
    endtask

    task automatic go_idle();
        en = 1'b0;
        run_periods(1);
    endtask

    task automatic test_reset();
        int pos[$];
        rst_n = 1'b0;
        en = 1'b0;
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        checks++; if (duty_cycle !== 8'h00) begin failures++; $display("FAIL reset_duty got=%h required=00", duty_cycle); end
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d required=0", phase); end
        checks++; if (period_end !== 1'b0) begin failures++; $display("FAIL reset_period_end got=%b required=0", period_end); end
        checks++; if (cycle_done !== 1'b0) begin failures++; $display("FAIL reset_cycle_done got=%b required=0", cycle_done); end
        rst_n = 1'b1;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (period_end) pos.push_back(k);
        end
        checks++;
        if (pos.size() != 4) begin
            failures++; $display("FAIL align_count got=%0d required=4", pos.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pos[i] != 255 + 256 * i) begin
                    failures++; $display("FAIL align_pos[%0d] got=%0d required=%0d", i, pos[i], 255 + 256 * i);
                end
            end
        end
        checks++; if (duty_cycle !== 8'h00 || phase !== 3'd0) begin failures++; $display("FAIL idle_hold got duty=%h phase=%0d required 00/0", duty_cycle, phase); end
    endtask

    task automatic test_basic_ramp();
        set_cfg(8'h10, 8'h40, 8'h10, 8'h00, 8'h01);
        en = 1'b1;
        run_periods(12);
        exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 8'h40, 8'h30, 8'h20, 8'h10, 8'h10, 8'h10, 8'h20};
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (seq[i] !== exp_q[i]) begin failures++; $display("FAIL ramp_seq[%0d] got=%h required=%h", i, seq[i], exp_q[i]); end
        end
        checks++; if (done_idx != 10) begin failures++; $display("FAIL ramp_cycle_done period got=%0d required=10", done_idx); end
    endtask

    task automatic test_clamp();
        go_idle();
        set_cfg(8'h05, 8'hFA, 8'h80, 8'h00, 8'h00);
        en = 1'b1;
        run_periods(8);
        exp_q = '{8'h05, 8'h85, 8'hFA, 8'hFA, 8'h7A, 8'h05, 8'h05, 8'h85};
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (seq[i] !== exp_q[i]) begin failures++; $display("FAIL clamp_seq[%0d] got=%h required=%h", i, seq[i], exp_q[i]); end
        end
        checks++; if (done_idx != 6) begin failures++; $display("FAIL clamp_cycle_done period got=%0d required=6", done_idx); end
    endtask

    task automatic test_prescale();
        go_idle();
        set_cfg(8'h20, 8'h30, 8'h00, 8'h03, 8'h00);
        en = 1'b1;
        run_periods(13);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (seq[i] !== 8'(8'h20 + i / 4)) begin
                failures++; $display("FAIL prescale_seq[%0d] got=%h required=%h", i, seq[i], 8'(8'h20 + i / 4));
            end
        end
    endtask

    task automatic test_degenerate();
        go_idle();
        set_cfg(8'h60, 8'h40, 8'h01, 8'h00, 8'h00);
        en = 1'b1;
        run_periods(6);
        exp_q = '{8'h60, 8'h40, 8'h40, 8'h60, 8'h60, 8'h40};
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (seq[i] !== exp_q[i]) begin failures++; $display("FAIL degen_seq[%0d] got=%h required=%h", i, seq[i], exp_q[i]); end
        end
    endtask

    task automatic test_en_drop();
        go_idle();
        set_cfg(8'h10, 8'h80, 8'h10, 8'h00, 8'h00);
        en = 1'b1;
        run_periods(3);
        checks++; if (seq[2] !== 8'h30) begin failures++; $display("FAIL drop_pre got=%h required=30", seq[2]); end
        repeat (100) @(negedge clk);
        en = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (duty_cycle !== 8'h30 || phase !== 3'd1) begin failures++; $display("FAIL drop_before_wrap got duty=%h phase=%0d required 30/1", duty_cycle, phase); end
        run_periods(1);
        checks++; if (seq[0] !== 8'h00 || phase !== 3'd0) begin failures++; $display("FAIL drop_after_wrap got duty=%h phase=%0d required 00/0", seq[0], phase); end
        en = 1'b1;
        run_periods(1);
        checks++; if (seq[0] !== 8'h10 || phase !== 3'd1) begin failures++; $display("FAIL drop_restart got duty=%h phase=%0d required 10/1", seq[0], phase); end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        go_idle();
        set_cfg(8'h10, 8'h20, 8'h10, 8'h00, 8'h05);
        en = 1'b1;
        run_periods(3);
        checks++; if (phase !== 3'd2 || duty_cycle !== 8'h20) begin failures++; $display("FAIL hold_entry got duty=%h phase=%0d required 20/2", duty_cycle, phase); end
        while (m_cnt != 255 && guard < 300) begin @(negedge clk); guard++; end
        checks++; if (period_end !== 1'b1) begin failures++; $display("FAIL pre_reset_pe got=%b required=1", period_end); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (duty_cycle !== 8'h00) begin failures++; $display("FAIL async_duty got=%h required=00", duty_cycle); end
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL async_phase got=%0d required=0", phase); end
        checks++; if (period_end !== 1'b0) begin failures++; $display("FAIL async_pe got=%b required=0", period_end); end
        checks++; if (cycle_done !== 1'b0) begin failures++; $display("FAIL async_cd got=%b required=0", cycle_done); end
        @(negedge clk);
        rst_n = 1'b1;
        run_periods(1);
        checks++; if (seq[0] !== 8'h10) begin failures++; $display("FAIL post_reset_start got=%h required=10", seq[0]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            set_cfg(8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 2)), 8'($urandom_range(0, 3)));
            en = 1'b1;
            for (int p = 0; p < 5; p++) begin
                repeat ($urandom_range(1, 200)) @(negedge clk);
                if ($urandom_range(0, 3) == 0)
                    set_cfg(8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)),
                            8'($urandom_range(0, 2)), 8'($urandom_range(0, 3)));
                if ($urandom_range(0, 7) == 0) en = ~en;
                while (m_cnt != 0) @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_ramp();
        test_clamp();
        test_prescale();
        test_degenerate();
        test_en_drop();
        test_async_reset();
        test_random();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_fade.md
# pwm_fade

Breathing-envelope generator that drives the 8-bit `duty_cycle` input of the downstream PWM stage. It ramps the duty from `min_duty` up to `max_duty` and holds there, then ramps back down and holds at the low end, repeating for as long as `en` is high. Duty changes happen only at 256-cycle PWM period boundaries, so the PWM never sees a mid-period duty change. It sits between the register/config logic and the PWM stage, and shares that stage's clock and reset release.

## Interface
- `DIV_W`, default 8: width of the prescaler; sets how many PWM periods pass between ramp steps.
- `clk`  in  1: system clock, the same one as the PWM stage.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: envelope enable.
- `step`  in  8: duty increment/decrement per ramp step; 0 is treated as 1.
- `min_duty`  in  8: low clamp and ramp start value.
- `max_duty`  in  8: high clamp.
- `div`  in  DIV_W: number of extra PWM periods per step; 0 means a step every period.
- `hold`  in  8: number of PWM periods to dwell in each HOLD state; 0 means leave at the next period end.
- `duty_cycle`  out  8: registered duty value, fed to the PWM stage.
- `phase`  out  3: current FSM state encoding.
- `period_end`  out  1: one-cycle pulse while the period counter reads 255.
- `cycle_done`  out  1: one-cycle pulse when HOLD_LO completes.

## Operation
- **Period counter `pcnt`** (8 bit):
  - Free-running 0..255 whenever `rst_n` is high, regardless of `en`.
  - Wraps 255→0.
- **Period end:** a "period end" is any cycle with `pcnt==255`.
- **All state changes happen at a period end.** FSM, prescaler, hold counter and `duty_cycle` update only on the edge where `pcnt` goes 255→0.
- **Prescaler `pre`** (DIV_W bit):
  - Counts period ends in UP and DOWN.
  - A step event occurs when `pre==div`; `pre` then clears.
  - `pre` clears on every state change.
- **FSM states:** IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.
- **IDLE:**
  - `duty_cycle`=0.
  - At a period end with `en`=1: go to UP and load `duty_cycle`=`min_duty`.
- **UP:**
  - On a step event, form the 9-bit sum `duty+step`.
  - If the sum ≥ `max_duty` (this covers 8-bit overflow), load `duty_cycle`=`max_duty` and go to HOLD_HI.
  - Otherwise load the sum.
- **HOLD_HI:**
  - The hold counter counts period ends.
  - When the count reaches `hold`, go to DOWN.
- **DOWN:**
  - On a step event, compute `duty-step` as a 9-bit signed value.
  - If the result is negative or ≤ `min_duty`, load `duty_cycle`=`min_duty` and go to HOLD_LO.
  - Otherwise load the result.
- **HOLD_LO:**
  - When the count reaches `hold`, pulse `cycle_done` and go to UP.
  - `duty_cycle` remains `min_duty`.
- **`en` deasserted in any non-IDLE state:** at the next period end, go to IDLE with `duty_cycle`=0. This takes priority over every other transition.
- **Degenerate config, `min_duty ≥ max_duty`:**
  - Legal.
  - UP clamps to `max_duty` on its first step.
  - DOWN clamps to `min_duty` on its first step.
  - Output alternates between the two values.
- **Config inputs** (`step`, `min_duty`, `max_duty`, `div`, `hold`) are sampled combinationally at period ends only. Changes between period ends have no effect.
- **Reset mid-operation:** asynchronously clears `pcnt`, `pre`, the hold counter, the FSM (to IDLE), `duty_cycle`, `period_end` and `cycle_done` to 0.

## Timing
- **Reset values:** `duty_cycle`=0, `phase`=0, `period_end`=0, `cycle_done`=0.
- **`period_end`:** registered and high for exactly 1 cycle every 256 cycles, in the cycle where `pcnt==255`.
- **`duty_cycle` update:**
  - Changes only on the clock edge on which `pcnt` becomes 0.
  - Stable for the whole following 256-cycle period.
  - This holds provided the PWM stage leaves reset on the same edge.
- **`en` latency:** a rise of `en` produces `duty_cycle`=`min_duty` at the first wrap after `en` is sampled high, which is 1–256 cycles later.
- **Ramp step spacing:** `(div+1)*256` cycles.
- **Hold duration:** `(hold+1)*256` cycles, counted from clamp to the next state change.
- **`cycle_done`:** high for 1 cycle, the cycle after the HOLD_LO→UP wrap edge.

## Structure
- **Shared package `pwm_pkg`:**
  - `PWM_W`=8.
  - `PWM_PERIOD`=256.
  - `fade_state_t` enum with the encodings above.
- **Sub-module `pwm_period_tick`:**
  - Contains the 8-bit free-running counter and the `period_end` generation.
  - Reused by other PWM-period-synchronous blocks.

## Test plan
- **Reset/alignment:** reset, hold `en`=0 for 1024 cycles → `duty_cycle`=0, `phase`=0, and `period_end` pulses at cycles 255, 511, 767, 1023.
- **Basic ramp:** `min`=0x10, `max`=0x40, `step`=0x10, `div`=0, `hold`=1, `en`=1 → `duty_cycle` goes 0x10, 0x20, 0x30, 0x40, each value lasting one 256-cycle period and changing only when `pcnt` wraps. It then stays at 0x40 for 512 cycles, descends 0x30, 0x20, 0x10, and `cycle_done` pulses after 512 cycles at 0x10.
- **Overflow/underflow clamp:** `min`=0x05, `max`=0xFA, `step`=0x80 → up sequence 0x05, 0x85, 0xFA; down sequence 0x7A, 0x05. No wrap to small or large values.
- **Prescaler and step=0:** `div`=3, `step`=0 → duty increments by 1 every 1024 cycles.
- **`en` drop mid-ramp:** `en` falls while in UP at duty 0x30 → duty stays 0x30 until the next wrap, then becomes 0 with `phase`=IDLE. Re-assertion restarts at `min_duty`.
- **Async reset mid-hold:** assert `rst_n`=0 between clock edges while in HOLD_HI → all outputs are 0 immediately, without waiting for a clock edge.
